// File: rtl/cam_emu_pkg.sv
// cam_emu_pkg: shared types and constants for the DVP camera emulator.
//   cam_state_t    : frame-timing FSM states
//   PAT_*          : pattern_sel encodings
//   BAR_*          : RGB565 colour-bar constants, left to right
//   bar_colour()   : maps a 3-bit bar index to its RGB565 colour
package cam_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } cam_state_t;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_COUNT = 2'd2;
  localparam logic [1:0] PAT_BLACK = 2'd3;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cam_dvp_emulator_if.sv
// cam_dvp_emulator_if: DVP video bus between the emulator and a pixel capture block.
//   v_sync   : active-high frame sync
//   h_ref    : active-high byte valid; the bus has no ready/back-pressure, a byte
//              is transferred on every clock where h_ref is high and the sink
//              must accept it; cam_data is 0 whenever h_ref is low
//   cam_data : RGB565 byte, high byte of each pixel first
// Modports: master drives the bus (emulator), slave receives it (capture path).
interface cam_dvp_emulator_if;
  logic       v_sync;
  logic       h_ref;
  logic [7:0] cam_data;

  modport master (output v_sync, output h_ref, output cam_data);
  modport slave  (input  v_sync, input  h_ref, input  cam_data);
endinterface

// File: rtl/cam_emu_pattern.sv
// cam_emu_pattern: test-pattern pixel generator.
//   clk, reset_n : clock / async active-low reset
//   clear        : start of frame, resets the running pixel index
//   load         : compute and register the pixel at (col, line)
//   col, line    : coordinates of the pixel being loaded
//   frame_lsb    : low bits of the completed-frame count (ramp blue channel)
//   pattern      : latched pattern select
//   pixel        : registered RGB565 pixel, valid from the cycle after load
// The top issues load one cycle ahead of the pixel's high byte, so pixel is
// stable for both byte slots of that pixel.
module cam_emu_pattern
  import cam_emu_pkg::*;
#(
  parameter int FRAME_WIDTH = 640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] col,
  input  logic [15:0] line,
  input  logic [4:0]  frame_lsb,
  input  logic [1:0]  pattern,
  output logic [15:0] pixel
);

  localparam int BAR_W = FRAME_WIDTH / 8;

  logic [2:0]  bar_idx_q, bar_idx_eff;
  logic [15:0] bar_cnt_q, bar_cnt_eff;
  logic [15:0] pix_idx_q;
  logic [15:0] pixel_d, pixel_q;
  logic        unused_line_bits;

  assign unused_line_bits = ^{line[15:8], line[1:0]};

  // Column 0 restarts the bar walk, so the bar counters need no end-of-line reset.
  always_comb begin
    bar_idx_eff = (col == 16'd0) ? 3'd0  : bar_idx_q;
    bar_cnt_eff = (col == 16'd0) ? 16'd0 : bar_cnt_q;
    case (pattern)
      PAT_BARS:  pixel_d = bar_colour(bar_idx_eff);
      PAT_RAMP:  pixel_d = {col[7:3], line[7:2], frame_lsb};
      PAT_COUNT: pixel_d = pix_idx_q;
      default:   pixel_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_idx_q <= 3'd0;
      bar_cnt_q <= 16'd0;
      pix_idx_q <= 16'd0;
      pixel_q   <= 16'd0;
    end else if (clear) begin
      bar_idx_q <= 3'd0;
      bar_cnt_q <= 16'd0;
      pix_idx_q <= 16'd0;
    end else if (load) begin
      pixel_q   <= pixel_d;
      pix_idx_q <= pix_idx_q + 16'd1;
      if (bar_cnt_eff == 16'(BAR_W - 1)) begin
        bar_idx_q <= bar_idx_eff + 3'd1;
        bar_cnt_q <= 16'd0;
      end else begin
        bar_idx_q <= bar_idx_eff;
        bar_cnt_q <= bar_cnt_eff + 16'd1;
      end
    end
  end

  assign pixel = pixel_q;

endmodule

// File: rtl/cam_dvp_emulator.sv
// cam_dvp_emulator: OV7670-style DVP transmitter emulating a camera sensor.
//   clk, reset_n  : byte clock / async active-low reset
//   enable        : frame start permission, sampled in IDLE and on the last VFP cycle
//   pattern_sel   : 0 bars, 1 ramp, 2 pixel counter, 3 black; latched at frame start
//   dvp           : v_sync / h_ref / cam_data bus (master side)
//   frame_done    : one-cycle pulse on the last cycle of each frame
//   frame_count   : completed frames, wrapping
//   busy          : high from frame start through end of front porch
//   state_dbg     : current FSM state
// Every output is registered from the FSM/counter state, so outputs lag the
// state register by one cycle uniformly and cam_data stays aligned with h_ref.
module cam_dvp_emulator
  import cam_emu_pkg::*;
#(
  parameter int FRAME_WIDTH   = 640,
  parameter int FRAME_HEIGHT  = 480,
  parameter int H_BLANK       = 144,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BACK_PORCH  = 17,
  parameter int V_FRONT_PORCH = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [1:0]          pattern_sel,
  cam_dvp_emulator_if.master  dvp,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic                busy,
  output cam_state_t          state_dbg
);

  localparam int LINE_LEN  = 2 * FRAME_WIDTH + H_BLANK;
  localparam int ACT_BYTES = 2 * FRAME_WIDTH;
  localparam int BW        = $clog2(LINE_LEN);

  cam_state_t  state_q, state_d;
  logic [BW-1:0] byte_cnt_q;
  logic [15:0] line_cnt_q, phase_lines;
  logic        line_end, phase_end, frame_start;
  logic [1:0]  pattern_q;
  logic [15:0] frame_count_q;

  logic        in_line_load, line_load, pat_load, pat_clear;
  logic [15:0] load_col, load_line, pixel;

  logic        v_sync_d, h_ref_d, busy_d, frame_done_d;
  logic [7:0]  cam_data_d;
  logic        v_sync_q, h_ref_q, busy_q, frame_done_q;
  logic [7:0]  cam_data_q;

  // Phase length and end-of-phase detection.
  always_comb begin
    case (state_q)
      ST_VBP:    phase_lines = 16'(V_BACK_PORCH);
      ST_ACTIVE: phase_lines = 16'(FRAME_HEIGHT);
      ST_VFP:    phase_lines = 16'(V_FRONT_PORCH);
      default:   phase_lines = 16'(VSYNC_LINES);
    endcase
    line_end  = (byte_cnt_q == BW'(LINE_LEN - 1));
    phase_end = line_end && (line_cnt_q == phase_lines - 16'd1);
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable)    state_d = ST_VSYNC;
      ST_VSYNC:  if (phase_end) state_d = ST_VBP;
      ST_VBP:    if (phase_end) state_d = ST_ACTIVE;
      ST_ACTIVE: if (phase_end) state_d = ST_VFP;
      ST_VFP:    if (phase_end) state_d = enable ? ST_VSYNC : ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  assign frame_start = (state_d == ST_VSYNC) && (state_q == ST_IDLE || state_q == ST_VFP);

  // Line/byte timing counters and per-frame latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_q    <= '0;
      line_cnt_q    <= 16'd0;
      pattern_q     <= PAT_BARS;
      frame_count_q <= 16'd0;
    end else begin
      if (state_q == ST_IDLE) begin
        byte_cnt_q <= '0;
        line_cnt_q <= 16'd0;
      end else if (line_end) begin
        byte_cnt_q <= '0;
        line_cnt_q <= phase_end ? 16'd0 : line_cnt_q + 16'd1;
      end else begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
      if (frame_start)  pattern_q     <= pattern_sel;
      if (frame_done_d) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  // Pixel look-ahead: the next pixel is loaded while the current low byte is
  // sent, and pixel 0 of each active line on the last cycle of the line before.
  always_comb begin
    in_line_load = (state_q == ST_ACTIVE) && byte_cnt_q[0] &&
                   (byte_cnt_q < BW'(ACT_BYTES - 1));
    line_load    = line_end &&
                   (((state_q == ST_ACTIVE) && (line_cnt_q != 16'(FRAME_HEIGHT - 1))) ||
                    ((state_q == ST_VBP) && (line_cnt_q == 16'(V_BACK_PORCH - 1))));
    pat_load     = in_line_load || line_load;
    pat_clear    = (state_q == ST_VSYNC);
    load_col     = line_load ? 16'd0 : 16'((int'(byte_cnt_q) + 1) / 2);
    if (line_load) load_line = (state_q == ST_ACTIVE) ? line_cnt_q + 16'd1 : 16'd0;
    else           load_line = line_cnt_q;
  end

  cam_emu_pattern #(.FRAME_WIDTH(FRAME_WIDTH)) u_pattern (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (pat_clear),
    .load      (pat_load),
    .col       (load_col),
    .line      (load_line),
    .frame_lsb (frame_count_q[4:0]),
    .pattern   (pattern_q),
    .pixel     (pixel)
  );

  // FSM: outputs (registered below).
  always_comb begin
    v_sync_d     = (state_q == ST_VSYNC);
    h_ref_d      = (state_q == ST_ACTIVE) && (byte_cnt_q < BW'(ACT_BYTES));
    cam_data_d   = 8'h00;
    if (h_ref_d) cam_data_d = byte_cnt_q[0] ? pixel[7:0] : pixel[15:8];
    busy_d       = (state_q != ST_IDLE);
    frame_done_d = (state_q == ST_VFP) && phase_end;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_sync_q     <= 1'b0;
      h_ref_q      <= 1'b0;
      cam_data_q   <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      v_sync_q     <= v_sync_d;
      h_ref_q      <= h_ref_d;
      cam_data_q   <= cam_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dvp.v_sync   = v_sync_q;
  assign dvp.h_ref    = h_ref_q;
  assign dvp.cam_data = cam_data_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/cam_dvp_emulator.md
# cam_dvp_emulator

Synthesizable OV7670-style DVP transmitter. It generates `v_sync`, `h_ref` and byte-serial RGB565 `cam_data` with camera-accurate frame/line timing and selectable test patterns. It drives the camera pixel processor's `v_sync`/`h_ref`/`cam_data` inputs in place of the physical sensor, for bring-up on the board and as the stimulus source in capture-path benches.

## Interface
Parameters:
- `FRAME_WIDTH`, 640: active pixels per line; must be divisible by 8.
- `FRAME_HEIGHT`, 480: active lines per frame.
- `H_BLANK`, 144: byte clocks with `h_ref` low after each line's active bytes.
- `VSYNC_LINES`, 3: line periods with `v_sync` high.
- `V_BACK_PORCH`, 17: idle line periods between `v_sync` fall and the first active line.
- `V_FRONT_PORCH`, 10: idle line periods after the last active line.

Ports:
- `clk`  in  1  byte clock (PCLK equivalent); all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits frame start; sampled only at frame boundaries.
- `pattern_sel`  in  2  0 colour bars, 1 ramp, 2 pixel counter, 3 solid black; latched at frame start.
- `v_sync`  out  1  active-high frame sync.
- `h_ref`  out  1  active-high byte-valid.
- `cam_data`  out  8  pixel byte; 0 when `h_ref` is low.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.
- `frame_count`  out  16  completed frames; wraps 0xFFFF→0.
- `busy`  out  1  high from frame start through end of front porch.

## Operation
- LINE_LEN = 2·FRAME_WIDTH + H_BLANK cycles. `byte_cnt` runs 0..LINE_LEN-1; `line_cnt` counts line periods within the current phase.
- States: IDLE → VSYNC → VBP → ACTIVE → VFP → (VSYNC if `enable`, else IDLE).
  - IDLE: all outputs low. `enable`=1 → VSYNC; `pattern_sel` is latched and the frame/pixel counters are cleared.
  - VSYNC: `v_sync`=1 for VSYNC_LINES·LINE_LEN cycles.
  - VBP: idle for V_BACK_PORCH·LINE_LEN cycles.
  - ACTIVE: FRAME_HEIGHT line periods. `h_ref`=1 for `byte_cnt` < 2·FRAME_WIDTH, then low for H_BLANK cycles.
  - VFP: idle for V_FRONT_PORCH·LINE_LEN cycles. `frame_done` pulses on the last cycle and `frame_count` increments on the same edge.
- Bytes per pixel: high byte first (R[4:0],G[5:3]), then low byte (G[2:0],B[4:0]). This matches OV7670 RGB565 order.
- Patterns use x = pixel column and y = active line:
  - 0: eight bars of FRAME_WIDTH/8 pixels each: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The bar index advances by a width counter, not by division.
  - 1: R=x[7:3], G=y[7:2], B=frame_count[4:0].
  - 2: 16-bit pixel index y·FRAME_WIDTH+x, produced by an incrementing counter that wraps at 0xFFFF.
  - 3: 0000.
- `enable` deasserted mid-frame: the current frame completes, then the block goes to IDLE. `enable` is never sampled outside IDLE or the last VFP cycle.
- `pattern_sel` changes mid-frame take effect only at the next frame start.

## Timing
- Reset: `v_sync`, `h_ref`, `cam_data`, `frame_done`, `busy` = 0; `frame_count` = 0; state IDLE.
- All outputs are registered. `cam_data` changes on the same edge as `h_ref`, with no skew.
- Start latency: `enable` high in IDLE at edge N → `v_sync` and `busy` high after edge N+1.
- First `h_ref` rise: (VSYNC_LINES+V_BACK_PORCH)·LINE_LEN cycles after `v_sync` rise.
- Frame period: (VSYNC_LINES+V_BACK_PORCH+FRAME_HEIGHT+V_FRONT_PORCH)·LINE_LEN cycles. Back-to-back frames have no gap: `v_sync` rises on the cycle after `frame_done`.
- `busy` falls on the cycle after `frame_done` when returning to IDLE.
- Asynchronous reset mid-frame: all outputs drop immediately. No partial `frame_done` is issued.

## Structure
- Package `cam_emu_pkg`: state enum, pattern-select codes, the eight RGB565 bar constants.
- Sub-module `cam_emu_pattern`: takes column/line/frame counters and the latched pattern, and returns the 16-bit pixel; registered with a single-cycle look-ahead. The top level owns timing counters, the FSM and byte muxing.

## Test plan
Bench parameters: W=8, H=4, H_BLANK=4, VSYNC=1, VBP=1, VFP=1. This gives LINE_LEN=20 and a 140-cycle frame.
- Pattern 0, `enable` pulsed once: `v_sync` high 20 cycles; first `h_ref` 40 cycles after `v_sync` rise; line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00; four lines; `frame_done` at cycle 139; `busy` low at 140.
- Pattern 2: line 1 first pixel bytes 00 08; last pixel of frame 00 1F; `h_ref` high 16 cycles then low 4, every line.
- `enable` held high for 3 frames: `v_sync` rises every 140 cycles with no gap; `frame_count` reads 1, 2, 3.
- `enable` and `pattern_sel` changed mid-frame: current frame completes unchanged with the original pattern, then IDLE.
- Reset asserted during ACTIVE: outputs drop at once and no `frame_done`. After release, IDLE with `frame_count`=0.
- `frame_count` preset near wrap (force 0xFFFF): next `frame_done` → 0x0000.
